// File: rtl/io_channel_unit_pkg.sv
// Shared types and channel-map constants for the I/O channel responder.
package io_channel_unit_pkg;

  localparam logic [3:0] CH_IN_LO  = 4'd3;
  localparam logic [3:0] CH_IN_HI  = 4'd7;
  localparam logic [3:0] CH_OUT_LO = 4'd8;

  typedef enum logic [1:0] {ChZero, ChScratch, ChIn, ChOut} ch_kind_e;

  typedef struct packed {
    logic        write_en;
    logic [3:0]  sel;
    logic [14:0] wr_data;
  } ctrl_t;

  typedef struct packed {
    logic [3:0]  ch;
    logic [14:0] data;
  } io_entry_t;

  function automatic ch_kind_e ch_kind(input logic [3:0] ch);
    if (ch == 4'd0)           return ChZero;
    else if (ch < CH_IN_LO)   return ChScratch;
    else if (ch <= CH_IN_HI)  return ChIn;
    else                      return ChOut;
  endfunction

endpackage

// File: rtl/io_channel_unit_if.sv
// Decode-stage channel port plus peripheral input/output streams.
interface io_channel_unit_if;

  logic [3:0]  ch_sel;
  logic        ch_write_en;
  logic [14:0] ch_wr_data;
  logic [14:0] ch_rd_data;
  logic        ch_stall;
  logic        in_valid;
  logic [3:0]  in_ch;
  logic [14:0] in_data;
  logic        out_valid;
  logic [3:0]  out_ch;
  logic [14:0] out_data;
  logic        out_ready;

  modport master (
    output ch_sel, ch_write_en, ch_wr_data, in_valid, in_ch, in_data, out_ready,
    input  ch_rd_data, ch_stall, out_valid, out_ch, out_data
  );

  modport slave (
    input  ch_sel, ch_write_en, ch_wr_data, in_valid, in_ch, in_data, out_ready,
    output ch_rd_data, ch_stall, out_valid, out_ch, out_data
  );

endinterface

// File: rtl/io_out_fifo.sv
// Outbound channel-write FIFO; head is driven from storage, never from the push data.
module io_out_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = io_channel_unit_pkg::io_entry_t
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  T     data_i,
  output logic full_o,
  input  logic pop_i,
  output logic empty_o,
  output T     head_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] CntFull = (PtrW + 1)'(DEPTH);

  T                mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PtrW:0]   cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == CntFull);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    head_o = '0;
    if (!empty_o) head_o = mem_q[rptr_q];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/io_channel_unit.sv
// Channel register file answering the decode stage, with input latching and an output FIFO.
module io_channel_unit
  import io_channel_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic               clock,
  input logic               rst_l,
  io_channel_unit_if.slave  bus
);

  ctrl_t       ctrl;
  logic [14:0] chan_q [16];
  logic [14:0] chan_d [16];
  logic        out_wr, push, pop, fifo_full, fifo_empty;
  io_entry_t   head, entry;

  always_comb begin
    ctrl.write_en = bus.ch_write_en;
    ctrl.sel      = bus.ch_sel;
    ctrl.wr_data  = bus.ch_wr_data;
  end

  assign out_wr     = ctrl.write_en && (ch_kind(ctrl.sel) == ChOut);
  assign push       = out_wr && !fifo_full;
  assign pop        = bus.out_ready && !fifo_empty;
  assign entry.ch   = ctrl.sel;
  assign entry.data = ctrl.wr_data;

  assign bus.ch_stall   = out_wr && fifo_full;
  assign bus.ch_rd_data = chan_q[ctrl.sel];
  assign bus.out_valid  = !fifo_empty;
  assign bus.out_ch     = head.ch;
  assign bus.out_data   = head.data;

  // CPU and peripheral target disjoint channel ranges, so the updates never collide.
  always_comb begin
    chan_d = chan_q;
    if (ctrl.write_en && ch_kind(ctrl.sel) == ChScratch) chan_d[ctrl.sel] = ctrl.wr_data;
    if (push) chan_d[ctrl.sel] = ctrl.wr_data;
    if (bus.in_valid && ch_kind(bus.in_ch) == ChIn) chan_d[bus.in_ch] = bus.in_data;
    chan_d[0] = '0;
  end

  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) chan_q <= '{default: '0};
    else        chan_q <= chan_d;
  end

  io_out_fifo #(
    .DEPTH (DEPTH),
    .T     (io_entry_t)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (rst_l),
    .push_i  (push),
    .data_i  (entry),
    .full_o  (fifo_full),
    .pop_i   (pop),
    .empty_o (fifo_empty),
    .head_o  (head)
  );

endmodule
